// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to abort transactions whose done never arrives.
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [16*NUM_REQ-1:0]      req_cmd,
  output logic [NUM_REQ-1:0]         ack,
  output logic [15:0]                rd_data,
  output logic                       err,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       wrt,
  output logic [15:0]                cmd,
  input  logic                       done,
  input  logic [15:0]                spi_rd_data
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("spi_arbiter: unsupported parameter set");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, GAP} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [GAP_W-1:0] gap_cnt;
  logic            any_req;
  logic [ID_W-1:0] sel;
  logic [ID_W-1:0] idx;
  logic [15:0]     cmd_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cmd
    assign cmd_arr[g] = req_cmd[16*g +: 16];
  end

  // Scan from farthest to nearest after ptr so the nearest set bit wins last.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    idx     = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (req[idx]) begin
        any_req = 1'b1;
        sel     = idx;
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      wrt     <= 1'b0;
      cmd     <= '0;
      ack     <= '0;
      rd_data <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      gap_cnt <= '0;
      ptr     <= ID_W'(NUM_REQ - 1);
`ifdef SPI_ARB_TIMEOUT_EN
      err     <= 1'b0;
      to_cnt  <= '0;
`endif
    end else begin
      wrt <= 1'b0;
      ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id <= sel;
            cmd    <= cmd_arr[sel];
            ptr    <= sel;
            busy   <= 1'b1;
            wrt    <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt <= '0;
`endif
          state <= BUSY;
        end
        BUSY: begin
          if (done) begin
            rd_data <= spi_rd_data;
            ack     <= NUM_REQ'(1) << gnt_id;
            state   <= RESP;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            rd_data <= 16'hFFFF;
            ack     <= NUM_REQ'(1) << gnt_id;
            err     <= 1'b1;
            state   <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end
        RESP: begin
          busy <= 1'b0;
          if (GAP_CYCLES == 0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= GAP_W'(GAP_CYCLES);
            state   <= GAP;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt <= GAP_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a fixed-latency SPI master model.
`timescale 1ns/1ps
module tb_spi_arbiter;
  localparam int NUM_REQ = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NUM_REQ-1:0]   req = '0;
  logic [16*NUM_REQ-1:0] req_cmd = '0;
  logic [NUM_REQ-1:0]   ack;
  logic [15:0]          rd_data;
  logic                 err;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 wrt;
  logic [15:0]          cmd;
  logic                 done;
  logic [15:0]          spi_rd_data;

  logic       model_done;
  logic       inj_done = 1'b0;
  logic       spi_en = 1'b1;
  logic [3:0] lat_cnt;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  bit         outstanding = 0;

  spi_arbiter #(.NUM_REQ(4), .GAP_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_cmd(req_cmd), .ack(ack),
    .rd_data(rd_data), .err(err), .gnt_id(gnt_id), .busy(busy), .wrt(wrt),
    .cmd(cmd), .done(done), .spi_rd_data(spi_rd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign done = model_done | inj_done;

  // SPI master model: done three cycles after the wrt cycle, data = cmd + 0x71A5
  always @(posedge clk) begin
    model_done <= 1'b0;
    if (!rst_n) begin
      lat_cnt     <= '0;
      spi_rd_data <= '0;
    end else if (wrt && spi_en) begin
      lat_cnt <= 4'd3;
    end else if (lat_cnt != 0) begin
      lat_cnt <= lat_cnt - 4'd1;
      if (lat_cnt == 4'd1) begin
        model_done  <= 1'b1;
        spi_rd_data <= cmd + 16'h71A5;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (wrt) begin
        checks++;
        if (outstanding || busy !== 1'b1) begin
          errors++;
          $display("FAIL wrt_single_outstanding: outstanding=%0d busy=%b, required no outstanding and busy=1", outstanding, busy);
        end
        outstanding = 1;
      end
      if (ack != 0) outstanding = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; req = '0; inj_done = 1'b0; spi_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int limit, output bit found, output int at);
    found = 0;
    at = 0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      if (ack != 0) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL ack_wait: no ack within %0d cycles, required one", limit);
    end
  endtask

  task automatic wait_wrt(input int limit, output bit found, output int at);
    found = 0;
    at = 0;
    for (int k = 0; k < limit && !found; k++) begin
      @(negedge clk);
      if (wrt === 1'b1) begin
        found = 1;
        at = cyc;
      end
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wrt_wait: no wrt within %0d cycles, required one", limit);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b required 0", wrt); end
    checks++; if (cmd !== 16'h0) begin errors++; $display("FAIL reset_cmd: got %h required 0000", cmd); end
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack: got %b required 0000", ack); end
    checks++; if (rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h required 0000", rd_data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id: got %0d required 0", gnt_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || wrt !== 1'b0) begin errors++; $display("FAIL idle_no_req: busy=%b wrt=%b required 0 0", busy, wrt); end
  endtask

  task automatic test_single();
    int t, at;
    bit found;
    do_reset();
    @(posedge clk); #1;
    req_cmd[15:0] = 16'h8F00; req = 4'b0001; t = cyc;
    @(negedge clk); @(negedge clk);
    checks++; if (wrt !== 1'b1) begin errors++; $display("FAIL single_wrt: got %b required 1 at T+1", wrt); end
    checks++; if (cmd !== 16'h8F00) begin errors++; $display("FAIL single_cmd: got %h required 8f00", cmd); end
    checks++; if (gnt_id !== 2'd0 || busy !== 1'b1) begin errors++; $display("FAIL single_grant: gnt_id=%0d busy=%b required 0 1", gnt_id, busy); end
    @(negedge clk);
    checks++; if (wrt !== 1'b0) begin errors++; $display("FAIL single_wrt_len: got %b required 0", wrt); end
    wait_ack(20, found, at);
    if (found) begin
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b required 0001", ack); end
      checks++; if (rd_data !== 16'h00A5) begin errors++; $display("FAIL single_rd_data: got %h required 00a5", rd_data); end
      checks++; if (gnt_id !== 2'd0 || err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_ack_ctl: gnt_id=%0d err=%b busy=%b required 0 0 1", gnt_id, err, busy); end
      checks++; if (at !== t + 6) begin errors++; $display("FAIL single_latency: ack at %0d required %0d", at, t + 6); end
    end
    @(posedge clk); #1 req = '0;
    @(negedge clk);
    checks++; if (ack !== 4'b0 || busy !== 1'b0 || rd_data !== 16'h00A5) begin errors++; $display("FAIL single_after: ack=%b busy=%b rd_data=%h required 0000 0 00a5", ack, busy, rd_data); end
  endtask

  task automatic test_round_robin();
    int at, prev, exp_id;
    bit found;
    logic [15:0] exp_rd;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) req_cmd[16*i +: 16] = 16'(16'h1100 * (i + 1));
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ack(40, found, at);
      if (!found) break;
      exp_id = k % NUM_REQ;
      exp_rd = 16'(16'h1100 * (exp_id + 1) + 16'h71A5);
      checks++; if (gnt_id !== 2'(exp_id) || ack !== 4'(1 << exp_id)) begin errors++; $display("FAIL rr_order%0d: gnt_id=%0d ack=%b required %0d", k, gnt_id, ack, exp_id); end
      checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rr_data%0d: got %h required %h", k, rd_data, exp_rd); end
      if (k > 0) begin
        checks++; if (at - prev !== 11) begin errors++; $display("FAIL rr_spacing%0d: got %0d cycles required 11", k, at - prev); end
      end
      prev = at;
    end
    @(posedge clk); #1 req = '0;
  endtask

  task automatic test_fairness();
    int at;
    bit found;
    do_reset();
    @(posedge clk); #1 req = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      wait_ack(40, found, at);
      if (!found) break;
      checks++; if (gnt_id !== ((k % 2 == 0) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL fair_order%0d: gnt_id=%0d required %0d", k, gnt_id, (k % 2 == 0) ? 2 : 3); end
    end
    @(posedge clk); #1 req = '0;
  endtask

  task automatic test_withdraw();
    int at, n;
    bit found;
    do_reset();
    @(posedge clk); #1 req = 4'b0001;
    repeat (3) @(posedge clk);
    #1 req[1] = 1'b1;
    @(posedge clk); #1 req[1] = 1'b0;
    wait_ack(20, found, at);
    if (found) begin
      checks++; if (ack !== 4'b0001 || gnt_id !== 2'd0) begin errors++; $display("FAIL withdraw_ack: ack=%b gnt_id=%0d required 0001 0", ack, gnt_id); end
    end
    @(posedge clk); #1 req = '0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (ack != 0 || wrt) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL withdraw_no_grant: %0d ack/wrt cycles required 0", n); end
  endtask

  task automatic test_reset_mid();
    int at;
    bit found;
    do_reset();
    @(posedge clk); #1 req = 4'b0001;
    wait_ack(20, found, at);
    @(posedge clk); #1 req = 4'b1001;
    wait_wrt(20, found, at);
    if (found) begin
      checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL midrst_pre_grant: gnt_id=%0d required 3", gnt_id); end
    end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || wrt !== 1'b0 || ack !== 4'b0 || err !== 1'b0) begin errors++; $display("FAIL midrst_ctl: busy=%b wrt=%b ack=%b err=%b required all 0", busy, wrt, ack, err); end
    checks++; if (gnt_id !== 2'd0 || cmd !== 16'h0 || rd_data !== 16'h0) begin errors++; $display("FAIL midrst_data: gnt_id=%0d cmd=%h rd_data=%h required 0", gnt_id, cmd, rd_data); end
    wait_ack(20, found, at);
    if (found) begin
      checks++; if (gnt_id !== 2'd0 || ack !== 4'b0001) begin errors++; $display("FAIL midrst_first_grant: gnt_id=%0d ack=%b required 0 0001", gnt_id, ack); end
    end
    @(posedge clk); #1 req = '0;
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int w, at, n;
    bit found;
    do_reset();
    @(posedge clk); #1 spi_en = 1'b0; req = 4'b0001;
    wait_wrt(20, found, w);
    wait_ack(200, found, at);
    if (found) begin
      checks++; if (at !== w + 65) begin errors++; $display("FAIL timeout_latency: ack at %0d required %0d", at, w + 65); end
      checks++; if (err !== 1'b1 || ack !== 4'b0001) begin errors++; $display("FAIL timeout_err: err=%b ack=%b required 1 0001", err, ack); end
      checks++; if (rd_data !== 16'hFFFF) begin errors++; $display("FAIL timeout_rd_data: got %h required ffff", rd_data); end
    end
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1 inj_done = 1'b1;
    @(posedge clk); #1 inj_done = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack != 0 || err) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL timeout_late_done: %0d extra ack cycles required 0", n); end
    spi_en = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fairness();
    test_withdraw();
    test_reset_mid();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
